// File: rtl/address_encoder.sv
// address_encoder: round-robin arbiter that encodes one requesting word (of 8)
// into a 3-bit index and offers it downstream with a valid/ready handshake.
//
// Ports
//   clk      : clock, rising-edge active
//   reset_n  : asynchronous active-low reset
//   request  : per-word access request levels, bit i = word i
//   ready    : downstream accepts the offered address this cycle
//   address  : registered index of the offered word
//   valid    : registered, high while an address is offered
//   grant    : combinational one-hot acceptance strobe, bit[address] = valid & ready
module address_encoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] request,
    input  logic       ready,
    output logic [2:0] address,
    output logic       valid,
    output logic [7:0] grant
);

    localparam int unsigned N_WORDS = 8;
    localparam int unsigned ADDR_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [N_WORDS-1:0]  masked;
    logic                xfer;

    // First set bit of req in the circular order base, base+1, ..., base+7.
    function automatic logic [ADDR_W-1:0] pick(input logic [N_WORDS-1:0] req,
                                               input logic [ADDR_W-1:0]  base);
        logic [ADDR_W-1:0] idx;
        logic              found;
        pick  = base;
        found = 1'b0;
        for (int i = 0; i < N_WORDS; i++) begin
            idx = base + ADDR_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // valid is a direct decode of the state register, so it stays registered.
    assign valid = (state_q == OFFER);
    assign xfer  = valid & ready;

    // One-hot strobe for the word being accepted this cycle.
    always_comb begin
        grant          = N_WORDS'(0);
        grant[address] = xfer;
    end

    // State, pointer and address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= ADDR_W'(0);
            address <= ADDR_W'(0);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            address <= addr_d;
        end
    end

    // Next-state: arbitrate from IDLE, or hold/advance an offer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = address;
        // The word being accepted still shows its request bit this cycle.
        masked  = request & ~grant;
        case (state_q)
            IDLE: begin
                if (|request) begin
                    addr_d  = pick(request, ptr_q);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ready) begin
                    ptr_d = address + ADDR_W'(1);
                    if (|masked) begin
                        addr_d = pick(masked, ptr_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
